eth_pack_buf: RTL and testbench

ETH_PACK_BUF -- requirements
Module: eth_pack_buf

---
 rtl/eth_pack_buf.sv | 159 +++++++++++++++
 tb/tb_eth_pack_buf.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pack_buf.sv
// Byte-stream to Ethernet frame packer: FWFT byte FIFO feeding a header/payload
// emitter that cuts full frames, flushes stale partial frames and pads short ones.
module eth_pack_buf #(
    parameter int          DEPTH       = 2048,
    parameter int          PAYLOAD_LEN = 1024,
    parameter int          MIN_LEN     = 46,
    parameter int          TIMEOUT     = 1000,
    parameter logic [47:0] DEST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h020000000001,
    parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_frame_axis_tdata,
    input  logic        s_frame_axis_tvalid,
    output logic        s_frame_axis_tready,
    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,
    output logic [15:0] status_frame_count,
    output logic        status_flush
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = 11;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PAY_C   = CW'(PAYLOAD_LEN);
    localparam logic [LW-1:0] PAY_L   = LW'(PAYLOAD_LEN);
    localparam logic [LW-1:0] MIN_C   = LW'(MIN_LEN);
    localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;

    function automatic logic [LW-1:0] frame_len(input logic [LW-1:0] l);
        return (l < MIN_C) ? MIN_C : l;
    endfunction

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en, rd_en;

    state_t        state;
    logic [LW-1:0] len_l, total_l, sent;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   frame_count;
    logic          flush_r;
    logic          pay_hs, start_full, start_flush;

    // Outputs are forced low while rst is held so a mid-frame reset is visible at once.
    assign s_frame_axis_tready       = !rst && (count < DEPTH_C);
    assign m_eth_hdr_valid           = !rst && (state == HDR);
    assign m_eth_payload_axis_tvalid = !rst && ((state == DATA) || (state == PAD));
    assign m_eth_payload_axis_tdata  = (state == PAD) ? 8'h00 : mem[rd_ptr];
    assign m_eth_payload_axis_tlast  = m_eth_payload_axis_tvalid && (sent == total_l - 1'b1);
    assign m_eth_payload_axis_tuser  = 1'b0;
    assign m_eth_dest_mac            = DEST_MAC;
    assign m_eth_src_mac             = SRC_MAC;
    assign m_eth_type                = ETH_TYPE;
    assign status_frame_count        = frame_count;
    assign status_flush              = flush_r && !rst;

    assign wr_en       = s_frame_axis_tvalid && s_frame_axis_tready;
    assign pay_hs      = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
    assign rd_en       = pay_hs && (state == DATA);
    assign start_full  = (state == IDLE) && (count >= PAY_C);
    assign start_flush = (state == IDLE) && (TIMEOUT != 0) && (count != '0)
                         && (count < PAY_C) && (idle_cnt == TMO_C);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= s_frame_axis_tdata;
    end

    // FIFO pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_l       <= '0;
            total_l     <= '0;
            sent        <= '0;
            idle_cnt    <= '0;
            frame_count <= '0;
            flush_r     <= 1'b0;
        end else begin
            flush_r <= 1'b0;

            if ((state != IDLE) || start_full || start_flush || wr_en || (count == '0))
                idle_cnt <= '0;
            else if (idle_cnt != TMO_C)
                idle_cnt <= idle_cnt + 1'b1;

            if (pay_hs && m_eth_payload_axis_tlast)
                frame_count <= frame_count + 1'b1;

            case (state)
                IDLE: begin
                    sent <= '0;
                    if (start_full) begin
                        state   <= HDR;
                        len_l   <= PAY_L;
                        total_l <= frame_len(PAY_L);
                    end else if (start_flush) begin
                        state   <= HDR;
                        len_l   <= LW'(count);
                        total_l <= frame_len(LW'(count));
                        flush_r <= 1'b1;
                    end
                end
                HDR: begin
                    if (m_eth_hdr_ready)
                        state <= DATA;
                end
                DATA: begin
                    if (pay_hs) begin
                        sent <= sent + 1'b1;
                        if (sent == len_l - 1'b1)
                            state <= (len_l < MIN_C) ? PAD : IDLE;
                    end
                end
                PAD: begin
                    if (pay_hs) begin
                        sent <= sent + 1'b1;
                        if (sent == MIN_C - 1'b1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_pack_buf.sv
// Bench for eth_pack_buf: frame-level reference model checked every cycle plus
// directed scenarios for full frames, timeout flush, backpressure, random stalls and reset.
module tb_eth_pack_buf;
    localparam int DEPTH = 128;
    localparam int PL    = 64;
    localparam int ML    = 46;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        hv;
    logic        h_rdy = 1'b0;
    logic [47:0] dmac, smac;
    logic [15:0] etype;
    logic [7:0]  tdata;
    logic        tv, tl, tu;
    logic        p_rdy = 1'b0;
    logic [15:0] fc;
    logic        fl;

    always #5 clk = ~clk;

    eth_pack_buf #(.DEPTH(DEPTH), .PAYLOAD_LEN(PL), .MIN_LEN(ML), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_frame_axis_tdata(s_tdata), .s_frame_axis_tvalid(s_tvalid), .s_frame_axis_tready(s_tready),
        .m_eth_hdr_valid(hv), .m_eth_hdr_ready(h_rdy),
        .m_eth_dest_mac(dmac), .m_eth_src_mac(smac), .m_eth_type(etype),
        .m_eth_payload_axis_tdata(tdata), .m_eth_payload_axis_tvalid(tv),
        .m_eth_payload_axis_tready(p_rdy), .m_eth_payload_axis_tlast(tl),
        .m_eth_payload_axis_tuser(tu),
        .status_frame_count(fc), .status_flush(fl)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    byte unsigned in_q[$];
    byte unsigned fr_q[$];
    int     occ = 0, prev_occ = 0, fr_L = 0, fr_len = 0, fr_idx = 0, fcount_m = 0;
    int     last_len = 0;
    logic [7:0] last_data = '0, prev_data = '0;
    bit     in_frame = 0, prev_hdr = 0, prev_stall = 0, post_rst = 0;
    bit     wr, rd, hdr_rise;
    longint cyc = 0, last_wr_cyc = 0, flush_cyc = -1;

    bit rand_en = 0;
    bit pay_cfg = 1, hdr_cfg = 1;

    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            p_rdy = ($urandom_range(0, 9) < 3);
            h_rdy = ($urandom_range(0, 9) < 3);
        end else begin
            p_rdy = pay_cfg;
            h_rdy = hdr_cfg;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_tready", s_tready, 0);
            chk("rst_hdr_valid", hv, 0);
            chk("rst_tvalid", tv, 0);
            chk("rst_tlast", tl, 0);
            chk("rst_flush", fl, 0);
            in_q.delete();
            fr_q.delete();
            occ = 0; prev_occ = 0; in_frame = 0; prev_hdr = 0; prev_stall = 0;
            fcount_m = 0; post_rst = 1;
        end else begin
            wr = 0; rd = 0;
            if (post_rst) begin
                chk("post_rst_hdr_valid", hv, 0);
                chk("post_rst_tvalid", tv, 0);
                chk("post_rst_flush", fl, 0);
                post_rst = 0;
            end
            chk("tready_vs_occupancy", s_tready, occ < DEPTH);
            chk("hdr_pay_exclusive", hv && tv, 0);
            chk("tuser", tu, 0);
            chk("tlast_without_tvalid", tl && !tv, 0);
            chk("frame_count", fc, 16'(fcount_m));
            if (prev_stall) begin
                chk("stall_tvalid", tv, 1);
                chk("stall_tdata", tdata, prev_data);
            end
            hdr_rise = hv && !prev_hdr;
            chk("status_flush", fl, hdr_rise && (prev_occ < PL));
            if (fl) flush_cyc = cyc;
            if (hdr_rise) begin
                chk("hdr_during_frame", in_frame, 0);
                fr_L   = (prev_occ >= PL) ? PL : prev_occ;
                fr_len = (fr_L < ML) ? ML : fr_L;
                fr_q.delete();
                for (int i = 0; i < fr_len; i++) begin
                    if (i < fr_L && in_q.size() > 0) fr_q.push_back(in_q.pop_front());
                    else fr_q.push_back(8'h00);
                end
                in_frame = 1;
                fr_idx = 0;
            end
            if (hv) begin
                chk("dest_mac", dmac, 48'hFFFFFFFFFFFF);
                chk("src_mac", smac, 48'h020000000001);
                chk("eth_type", etype, 16'h88B5);
            end
            if (tv) begin
                if (!in_frame) begin
                    chk("tvalid_outside_frame", tv, 0);
                end else begin
                    chk("payload_tdata", tdata, fr_q[fr_idx]);
                    chk("payload_tlast", tl, fr_idx == fr_len - 1);
                    if (p_rdy) begin
                        if (fr_idx < fr_L) rd = 1;
                        if (fr_idx == fr_len - 1) begin
                            in_frame = 0;
                            fcount_m++;
                            last_len = fr_len;
                            last_data = tdata;
                        end
                        fr_idx++;
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                in_q.push_back(s_tdata);
                wr = 1;
                last_wr_cyc = cyc;
            end
            prev_occ   = occ;
            occ        = occ + int'(wr) - int'(rd);
            prev_hdr   = hv;
            prev_stall = tv && !p_rdy;
            prev_data  = tdata;
        end
    end

    task automatic wait_accept();
        int k = 0;
        @(negedge clk);
        while (!s_tready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!s_tready) chk("accept_timeout", s_tready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(base + i);
            wait_accept();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (fcount_m < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", fcount_m >= n, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        longint d;
        bit took;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Full frame 0..63
        send(64, 0);
        wait_frames(1, 500);
        chk("t1_frame_count", fc, 1);
        chk("t1_len", last_len, 64);
        chk("t1_last_byte", last_data, 63);

        // Short frame flushed by timeout and padded
        flush_cyc = -1;
        send(10, 100);
        wait_frames(2, 1000);
        d = flush_cyc - last_wr_cyc;
        chk("t2_flush_delay", (flush_cyc > 0) && (d >= 100) && (d <= 102), 1);
        chk("t2_len", last_len, 46);
        chk("t2_last_byte", last_data, 0);
        chk("t2_frame_count", fc, 2);

        // Backpressure: 200 bytes with payload tready low
        pay_cfg = 0;
        acc = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 250; c++) begin
            s_tdata = 8'(acc);
            @(negedge clk);
            took = s_tready;
            @(posedge clk); #1;
            if (took) acc++;
        end
        s_tvalid = 1'b0;
        chk("t3_accepted_when_full", acc, 128);
        chk("t3_tready_full", s_tready, 0);
        pay_cfg = 1;
        send(200 - acc, acc);
        wait_frames(6, 3000);
        chk("t3_frame_count", fc, 6);
        chk("t3_tail_len", last_len, 46);

        // Random 30% ready on header and payload
        rand_en = 1;
        send(128, 8'h33);
        wait_frames(8, 5000);
        rand_en = 0;
        chk("t4_len", last_len, 64);
        chk("t4_last_byte", last_data, 8'hB2);
        chk("t4_frame_count", fc, 8);

        // Reset on the 20th payload byte
        repeat (2) @(posedge clk); #1;
        send(64, 8'hC0);
        begin
            int k = 0;
            while (!(in_frame && fr_idx == 19) && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk("t5_reach_byte20", in_frame && fr_idx == 19, 1);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_count_cleared", fc, 0);
        chk("t5_tready_after_rst", s_tready, 1);
        @(posedge clk); #1;
        send(64, 8'h40);
        wait_frames(1, 500);
        chk("t5_frame_count", fc, 1);
        chk("t5_len", last_len, 64);
        chk("t5_last_byte", last_data, 8'h7F);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
